// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: controller states, round count,
// the Rcon seed and polynomial, and the GF(2^8) doubling helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        FINISH  = 2'd2
    } state_e;

    localparam int         AES_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/key_schedule_controller_g_function.sv
// Key-schedule g function: RotWord, SubWord, then Rcon into the top byte.
// Purely combinational, no handshake.
module g_function (
    input  logic [31:0] w_in,
    input  logic [7:0]  rcon,
    output logic [31:0] g_out
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    logic [31:0] rot_w;

    always_comb begin
        rot_w = {w_in[23:0], w_in[31:24]};
        g_out = {sub_byte(rot_w[31:24]) ^ rcon, sub_byte(rot_w[23:16]),
                 sub_byte(rot_w[15:8]), sub_byte(rot_w[7:0])};
    end

endmodule

// File: rtl/key_schedule_controller.sv
// AES-128 key expansion sequencer: round key 0 one cycle after start, then one key per accept.
// Valid/ready output: key and index hold until accepted; start is ignored while not idle.
module key_schedule_controller #(
    parameter int         NUM_ROUNDS = aes_pkg::AES_ROUNDS,
    parameter logic [7:0] RCON_INIT  = aes_pkg::RCON_INIT
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_e       state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_num_q, round_num_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [31:0]  g_w;
    logic [31:0]  n0, n1, n2, n3;

    g_function u_g_function (
        .w_in  (round_key_q[31:0]),
        .rcon  (rcon_q),
        .g_out (g_w)
    );

    always_comb begin
        n0 = round_key_q[127:96] ^ g_w;
        n1 = round_key_q[95:64]  ^ n0;
        n2 = round_key_q[63:32]  ^ n1;
        n3 = round_key_q[31:0]   ^ n2;
    end

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rcon_d      = rcon_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    round_key_d = key_in;
                    round_num_d = 4'd0;
                    rcon_d      = RCON_INIT;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (rk_valid_q && rk_ready) begin
                    if (round_num_q == LAST_ROUND) begin
                        // Final key and index stay visible after the handshake.
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        round_key_d = {n0, n1, n2, n3};
                        round_num_d = round_num_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_num_q <= 4'd0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rcon_q      <= RCON_INIT;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rcon_q      <= rcon_d;
        end
    end

    assign round_key = round_key_q;
    assign rk_valid  = rk_valid_q;
    assign round_num = round_num_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_schedule_controller.sv
// Bench for key_schedule_controller: directed scenarios with random keys and
// random consumer stalls, checked against a FIPS-197 style key expansion model.
module tb_key_schedule_controller;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] round_key;
    logic         rk_valid;
    logic [3:0]   round_num;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb     [0:255];
    logic [127:0] m_rk   [0:10];
    logic [7:0]   m_rc   [1:10];
    logic [127:0] obs_rk [0:10];

    always #5 clk = ~clk;

    key_schedule_controller dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_valid  (rk_valid),
        .round_num (round_num),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] x;
        p = 8'h00;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                m_rc[i/4] = rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) m_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // One expansion starting at the current negedge; returns at the negedge after done.
    task automatic expand(input logic [127:0] key, input int stall_round,
                          input int busy_start_round, input int abort_round,
                          input bit rand_ready);
        int stalls;
        build_model(key);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~key;
        for (int r = 0; r <= 10; r++) begin
            chk("rk_valid", 128'(rk_valid), 128'(1'b1));
            chk("round_num", 128'(round_num), 128'(r));
            chk("round_key", round_key, m_rk[r]);
            chk("busy", 128'(busy), 128'(1'b1));
            chk("done_low", 128'(done), 128'(1'b0));
            if (r < 10) chk("rcon", 128'(dut.rcon_q), 128'(m_rc[r+1]));
            obs_rk[r] = round_key;
            if (r == abort_round) begin
                n_rst = 1'b0;
                #1;
                chk("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
                chk("rst_busy", 128'(busy), 128'(1'b0));
                chk("rst_round_num", 128'(round_num), 128'(0));
                chk("rst_round_key", round_key, 128'(0));
                chk("rst_done", 128'(done), 128'(1'b0));
                @(negedge clk);
                @(negedge clk);
                chk("rst_no_done", 128'(done), 128'(1'b0));
                n_rst = 1'b1;
                @(negedge clk);
                chk("post_rst_done", 128'(done), 128'(1'b0));
                chk("post_rst_valid", 128'(rk_valid), 128'(1'b0));
                return;
            end
            stalls = (r == stall_round) ? 5 : (rand_ready ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stalls; s++) begin
                rk_ready = 1'b0;
                @(negedge clk);
                chk("stall_key", round_key, m_rk[r]);
                chk("stall_num", 128'(round_num), 128'(r));
                chk("stall_valid", 128'(rk_valid), 128'(1'b1));
            end
            rk_ready = 1'b1;
            if (r == busy_start_round) begin
                start  = 1'b1;
                key_in = '1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("end_valid", 128'(rk_valid), 128'(1'b0));
        chk("end_busy", 128'(busy), 128'(1'b0));
        chk("done_pulse", 128'(done), 128'(1'b1));
        chk("end_num", 128'(round_num), 128'(10));
        chk("end_key", round_key, m_rk[10]);
        rk_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_once", 128'(done), 128'(1'b0));
        chk("idle_valid", 128'(rk_valid), 128'(1'b0));
        chk("idle_num", 128'(round_num), 128'(10));
    endtask

    initial begin
        logic [127:0] rkey;
        n_rst    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        init_sbox();
        @(negedge clk);
        chk("reset_key", round_key, 128'(0));
        chk("reset_valid", 128'(rk_valid), 128'(1'b0));
        chk("reset_num", 128'(round_num), 128'(0));
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_done", 128'(done), 128'(1'b0));
        chk("reset_rcon", 128'(dut.rcon_q), 128'(8'h01));
        n_rst = 1'b1;

        // Consumer ready while nothing is offered must not advance anything.
        rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready_valid", 128'(rk_valid), 128'(1'b0));
        chk("idle_ready_num", 128'(round_num), 128'(0));
        chk("idle_ready_busy", 128'(busy), 128'(1'b0));

        // FIPS-197 vector with a 5-cycle stall at round 3 and a start pulse at round 5.
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 3, 5, 99, 1'b0);
        chk("fips_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("rcon_r9", 128'(m_rc[9]), 128'(8'h1b));
        chk("rcon_r10", 128'(m_rc[10]), 128'(8'h36));

        // Back-to-back: restart in the cycle after done with random stalls.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        expand(rkey, 99, 99, 99, 1'b1);

        // Mid-run reset at round 7, then an all-zero key.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        expand(rkey, 99, 99, 7, 1'b1);
        expand(128'h0, 99, 99, 99, 1'b1);
        chk("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);

        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            expand(rkey, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 99, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
